// File: rtl/ifetch_stage.sv
// ---------------------------------------------------------------------------
// ifetch_stage -- instruction fetch stage for a 16-bit pipelined core.
//
// Issues one instruction-memory read per fetch and registers the returned word
// into the IF/ID pipeline register together with PC+2. A one-entry skid buffer
// catches a response that lands while the decoder is stalled. The stage
// flushes on redirect and stops permanently on HALT.
//
// Configuration macro:
//   IFETCH_ALIGN_CHK_EN - when defined, an attempt to fetch from an odd PC is
//                         suppressed. The stage halts and raises a sticky err.
//                         When undefined, err is tied low and odd PCs are
//                         fetched as-is.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous, active-high reset
//   stall        in   hold IF/ID, issue no new fetch
//   redirect     in   taken branch/jump: flush IF/ID and refetch
//   redirect_pc  in   [15:0] target PC, valid with redirect
//   halt_id      in   decoder reports HALT for the word in IF/ID
//   imem_rd      out  one-cycle read request
//   imem_addr    out  [15:0] fetch address (current PC)
//   imem_ready   in   response strobe, at least one cycle after imem_rd
//   imem_data    in   [15:0] instruction word, valid with imem_ready
//   ifid_instr   out  [15:0] registered instruction for the decoder
//   ifid_pc_inc  out  [15:0] registered PC+2 of ifid_instr
//   ifid_valid   out  ifid_instr is a real fetched instruction
//   halted       out  fetch stopped by HALT (or by an alignment fault)
//   err          out  misaligned fetch detected (sticky)
// ---------------------------------------------------------------------------
module ifetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_id,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_inc,
    output logic        ifid_valid,
    output logic        halted,
    output logic        err
);

    localparam logic [15:0] NOP_WORD = 16'h0800;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_reg,       state_next;
    logic [15:0] pc_reg,          pc_next;
    logic [15:0] ifid_instr_reg,  ifid_instr_next;
    logic [15:0] ifid_pc_inc_reg, ifid_pc_inc_next;
    logic        ifid_valid_reg,  ifid_valid_next;
    logic        skid_valid_reg,  skid_valid_next;
    logic [15:0] skid_instr_reg,  skid_instr_next;
    logic [15:0] skid_pc_inc_reg, skid_pc_inc_next;
    // Set when a redirect lands while a request is outstanding. The next
    // imem_ready belongs to the abandoned request and must be thrown away.
    logic        drop_reg,        drop_next;

    logic [15:0] pc_inc;
    logic        halt_req;
    logic        can_issue;
    logic        align_fault;

    // PC+2 wraps silently at 16 bits.
    assign pc_inc = pc_reg + 16'd2;

    // HALT applies only to a real instruction. Redirect overrides it.
    assign halt_req = halt_id && ifid_valid_reg && !redirect;

    // A new fetch may go out only from FETCH with nothing parked in the skid
    // buffer. A same-cycle redirect or halt also blocks it, so the old PC is
    // never requested.
    assign can_issue = (state_reg == ST_FETCH) && !stall && !skid_valid_reg
                       && !redirect && !halt_req;

`ifdef IFETCH_ALIGN_CHK_EN
    logic err_reg;

    assign align_fault = can_issue && pc_reg[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_reg | align_fault;
        end
    end

    assign err = err_reg;
`else
    assign align_fault = 1'b0;
    assign err         = 1'b0;
`endif

    // Gating with rst keeps the request low while reset is held, even though
    // the state register already reads FETCH.
    assign imem_rd     = can_issue && !align_fault && !rst;
    assign imem_addr   = pc_reg;
    assign ifid_instr  = ifid_instr_reg;
    assign ifid_pc_inc = ifid_pc_inc_reg;
    assign ifid_valid  = ifid_valid_reg;
    assign halted      = (state_reg == ST_HALTED);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_FETCH;
            pc_reg          <= 16'h0000;
            ifid_instr_reg  <= NOP_WORD;
            ifid_pc_inc_reg <= 16'h0000;
            ifid_valid_reg  <= 1'b0;
            skid_valid_reg  <= 1'b0;
            skid_instr_reg  <= 16'h0000;
            skid_pc_inc_reg <= 16'h0000;
            drop_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            ifid_instr_reg  <= ifid_instr_next;
            ifid_pc_inc_reg <= ifid_pc_inc_next;
            ifid_valid_reg  <= ifid_valid_next;
            skid_valid_reg  <= skid_valid_next;
            skid_instr_reg  <= skid_instr_next;
            skid_pc_inc_reg <= skid_pc_inc_next;
            drop_reg        <= drop_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        ifid_instr_next  = ifid_instr_reg;
        ifid_pc_inc_next = ifid_pc_inc_reg;
        ifid_valid_next  = ifid_valid_reg;
        skid_valid_next  = skid_valid_reg;
        skid_instr_next  = skid_instr_reg;
        skid_pc_inc_next = skid_pc_inc_reg;
        drop_next        = drop_reg;

        if (state_reg == ST_HALTED) begin
            // Terminal until reset. Every register holds.
            state_next = ST_HALTED;
        end else if (redirect) begin
            pc_next         = redirect_pc;
            ifid_instr_next = NOP_WORD;
            ifid_valid_next = 1'b0;
            skid_valid_next = 1'b0;
            if ((state_reg == ST_WAIT) && !imem_ready) begin
                // The old response is still in flight. Wait for it so it is
                // not mistaken for the response to the new target.
                state_next = ST_WAIT;
                drop_next  = 1'b1;
            end else begin
                state_next = ST_FETCH;
                drop_next  = 1'b0;
            end
        end else if (halt_req) begin
            // Any outstanding response is abandoned. IF/ID keeps the HALT word.
            state_next = ST_HALTED;
            drop_next  = 1'b0;
        end else if (state_reg == ST_WAIT) begin
            if (imem_ready) begin
                state_next = ST_FETCH;
                drop_next  = 1'b0;
                if (!drop_reg) begin
                    pc_next = pc_inc;
                    if (stall) begin
                        skid_valid_next  = 1'b1;
                        skid_instr_next  = imem_data;
                        skid_pc_inc_next = pc_inc;
                    end else begin
                        ifid_instr_next  = imem_data;
                        ifid_pc_inc_next = pc_inc;
                        ifid_valid_next  = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_valid_next = 1'b0;
                end
            end else if (!stall) begin
                // The decoder consumed the current word. Present a bubble so
                // the word is not issued twice.
                ifid_valid_next = 1'b0;
            end
        end else begin
            // ST_FETCH
            if (stall) begin
                // IF/ID and the skid buffer hold exactly.
                state_next = ST_FETCH;
            end else if (skid_valid_reg) begin
                // Stall just released: drain the parked word this edge.
                // No fetch goes out in the same cycle.
                ifid_instr_next  = skid_instr_reg;
                ifid_pc_inc_next = skid_pc_inc_reg;
                ifid_valid_next  = 1'b1;
                skid_valid_next  = 1'b0;
            end else begin
                ifid_valid_next = 1'b0;
                if (align_fault) begin
                    state_next = ST_HALTED;
                end else if (can_issue) begin
                    state_next = ST_WAIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// ---------------------------------------------------------------------------
// tb_ifetch_stage -- directed self-checking bench for ifetch_stage.
// A small memory responder answers each imem_rd after a configurable extra
// delay. Each test task drives its own stimulus and checks its own results.
// Memory image: 0000->4020, 0002->0800, any other address a -> a ^ A000.
// ---------------------------------------------------------------------------
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt_id;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_inc;
    logic        ifid_valid;
    logic        halted;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Responder state
    logic        pending     = 1'b0;
    logic [15:0] pend_addr   = 16'h0000;
    int          wait_cnt    = 0;
    int          extra_delay = 0;
    int          rd_count    = 0;

    ifetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_id     (halt_id),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .ifid_instr  (ifid_instr),
        .ifid_pc_inc (ifid_pc_inc),
        .ifid_valid  (ifid_valid),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000)      return 16'h4020;
        else if (a == 16'h0002) return 16'h0800;
        else                    return a ^ 16'hA000;
    endfunction

    // The responder works on the falling edge, away from the DUT's rising edge.
    always @(negedge clk) begin
        imem_ready = 1'b0;
        if (pending) begin
            if (wait_cnt == 0) begin
                imem_ready = 1'b1;
                imem_data  = mem_word(pend_addr);
                pending    = 1'b0;
                $display("RESP addr=%h data=%h", pend_addr, mem_word(pend_addr));
            end else begin
                wait_cnt = wait_cnt - 1;
            end
        end
        if (imem_rd) begin
            pending   = 1'b1;
            pend_addr = imem_addr;
            wait_cnt  = extra_delay;
            rd_count  = rd_count + 1;
            $display("REQ  addr=%h", imem_addr);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until ifid_valid is seen or the bound expires. Reports the cycle count.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!ifid_valid && cycles < 20);
        $display("IFID instr=%h pc_inc=%h valid=%b cycles=%0d", ifid_instr, ifid_pc_inc, ifid_valid, cycles);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        halt_id = 1'b0; imem_ready = 1'b0; imem_data = 16'h0000;
        repeat (2) step();
        checks++; if (ifid_instr !== 16'h0800) begin errors++; $display("FAIL reset_instr: got %h exp 0800", ifid_instr); end
        checks++; if (ifid_pc_inc !== 16'h0000) begin errors++; $display("FAIL reset_pc_inc: got %h exp 0000", ifid_pc_inc); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", ifid_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", halted); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b exp 0", imem_rd); end
    endtask

    task automatic test_basic();
        int cyc;
        rst = 1'b0;
        #1;
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL basic_first_req: got rd=%b addr=%h exp rd=1 addr=0000", imem_rd, imem_addr); end
        wait_valid(cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL basic_latency0: got %0d cycles exp 2", cyc); end
        checks++; if (ifid_instr !== 16'h4020 || ifid_pc_inc !== 16'h0002) begin errors++; $display("FAIL basic_word0: got %h/%h exp 4020/0002", ifid_instr, ifid_pc_inc); end
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0002) begin errors++; $display("FAIL basic_second_req: got rd=%b addr=%h exp rd=1 addr=0002", imem_rd, imem_addr); end
        wait_valid(cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL basic_latency1: got %0d cycles exp 2", cyc); end
        checks++; if (ifid_instr !== 16'h0800 || ifid_pc_inc !== 16'h0004 || ifid_valid !== 1'b1) begin errors++; $display("FAIL basic_word1: got %h/%h/%b exp 0800/0004/1", ifid_instr, ifid_pc_inc, ifid_valid); end
    endtask

    task automatic test_stall();
        int rc;
        // FETCH at PC 0004: the request goes out on this edge.
        step();
        // WAIT: response arrives under stall.
        stall = 1'b1;
        rc = rd_count;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            checks++; if (ifid_instr !== 16'h0800 || ifid_pc_inc !== 16'h0004 || ifid_valid !== 1'b0 || imem_rd !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: got %h/%h/%b rd=%b exp 0800/0004/0 rd=0", i, ifid_instr, ifid_pc_inc, ifid_valid, imem_rd);
            end
        end
        stall = 1'b0;
        #1;
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL stall_release_no_fetch: got rd=%b exp 0", imem_rd); end
        step();
        checks++; if (ifid_instr !== 16'hA004 || ifid_pc_inc !== 16'h0006 || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_skid_load: got %h/%h/%b exp A004/0006/1", ifid_instr, ifid_pc_inc, ifid_valid); end
        checks++; if (rd_count !== rc) begin errors++; $display("FAIL stall_no_refetch: got %0d reqs exp %0d", rd_count, rc); end
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0006) begin errors++; $display("FAIL stall_next_req: got rd=%b addr=%h exp rd=1 addr=0006", imem_rd, imem_addr); end
    endtask

    task automatic test_redirect();
        int cyc;
        extra_delay = 2;
        step();                         // WAIT on 0006, response held back
        redirect = 1'b1; redirect_pc = 16'h0100;
        #1;
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL redir_no_rd: got %b exp 0", imem_rd); end
        step();
        redirect = 1'b0; extra_delay = 0;
        #1;
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0800 || imem_rd !== 1'b0) begin errors++; $display("FAIL redir_flush: got %h/%b rd=%b exp 0800/0 rd=0", ifid_instr, ifid_valid, imem_rd); end
        step();
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL redir_still_wait: got rd=%b exp 0", imem_rd); end
        step();                         // stale response consumed on this edge
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0100 || ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_target_req: got rd=%b addr=%h valid=%b exp 1/0100/0", imem_rd, imem_addr, ifid_valid); end
        wait_valid(cyc);
        checks++; if (ifid_instr !== 16'hA100 || ifid_pc_inc !== 16'h0102 || cyc !== 2) begin errors++; $display("FAIL redir_target_word: got %h/%h cyc=%0d exp A100/0102 cyc=2", ifid_instr, ifid_pc_inc, cyc); end
    endtask

    task automatic test_halt();
        int rc;
        halt_id = 1'b1;
        #1;
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL halt_blocks_rd: got %b exp 0", imem_rd); end
        rc = rd_count;
        step();
        halt_id = 1'b0;
        #1;
        checks++; if (halted !== 1'b1 || ifid_instr !== 16'hA100 || ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_enter: got halted=%b %h/%b exp 1 A100/1", halted, ifid_instr, ifid_valid); end
        redirect = 1'b1; redirect_pc = 16'h0200;
        repeat (4) step();
        redirect = 1'b0;
        #1;
        checks++; if (halted !== 1'b1 || imem_rd !== 1'b0 || rd_count !== rc || ifid_instr !== 16'hA100) begin errors++; $display("FAIL halt_sticky: got halted=%b rd=%b reqs=%0d instr=%h exp 1/0/%0d/A100", halted, imem_rd, rd_count, ifid_instr, rc); end
    endtask

    task automatic test_reset_mid_request();
        int cyc;
        rst = 1'b1;
        #1;
        checks++; if (halted !== 1'b0 || ifid_valid !== 1'b0 || ifid_instr !== 16'h0800) begin errors++; $display("FAIL rst_from_halt: got halted=%b %h/%b exp 0 0800/0", halted, ifid_instr, ifid_valid); end
        step();
        rst = 1'b0;
        step();                         // WAIT on 0000
        rst = 1'b1;                     // reset with the response still in flight
        step();
        rst = 1'b0;
        #1;
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0800 || imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mid_req: got %h/%b rd=%b addr=%h exp 0800/0 rd=1 addr=0000", ifid_instr, ifid_valid, imem_rd, imem_addr); end
        wait_valid(cyc);
        checks++; if (ifid_instr !== 16'h4020 || ifid_pc_inc !== 16'h0002 || cyc !== 2) begin errors++; $display("FAIL rst_refetch: got %h/%h cyc=%0d exp 4020/0002 cyc=2", ifid_instr, ifid_pc_inc, cyc); end
    endtask

    task automatic test_redirect_over_halt_wrap();
        int cyc;
        halt_id = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE;
        #1;
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL over_halt_rd: got %b exp 0", imem_rd); end
        step();
        halt_id = 1'b0; redirect = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || ifid_valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 16'hFFFE) begin errors++; $display("FAIL over_halt: got halted=%b valid=%b rd=%b addr=%h exp 0/0/1/FFFE", halted, ifid_valid, imem_rd, imem_addr); end
        wait_valid(cyc);
        checks++; if (ifid_instr !== 16'h5FFE || ifid_pc_inc !== 16'h0000) begin errors++; $display("FAIL wrap_word: got %h/%h exp 5FFE/0000", ifid_instr, ifid_pc_inc); end
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_next_addr: got rd=%b addr=%h exp 1/0000", imem_rd, imem_addr); end
    endtask

    task automatic test_align();
        int cyc;
        redirect = 1'b1; redirect_pc = 16'h0013;
        step();
        redirect = 1'b0;
        #1;
`ifdef IFETCH_ALIGN_CHK_EN
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL align_no_rd: got %b exp 0", imem_rd); end
        step();
        checks++; if (err !== 1'b1 || halted !== 1'b1 || imem_rd !== 1'b0) begin errors++; $display("FAIL align_fault: got err=%b halted=%b rd=%b exp 1/1/0", err, halted, imem_rd); end
        cyc = 0;
`else
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0013 || err !== 1'b0) begin errors++; $display("FAIL align_issue: got rd=%b addr=%h err=%b exp 1/0013/0", imem_rd, imem_addr, err); end
        wait_valid(cyc);
        checks++; if (ifid_instr !== 16'hA013 || ifid_pc_inc !== 16'h0015) begin errors++; $display("FAIL align_word: got %h/%h exp A013/0015", ifid_instr, ifid_pc_inc); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_halt();
        test_reset_mid_request();
        test_redirect_over_halt_wrap();
        test_align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 stall  in  1  from hazard unit: hold IF/ID contents, issue no new fetch.
REQ-004 redirect  in  1  taken branch/jump from ID/EX: flush and refetch.
REQ-005 redirect_pc  in  16  target PC, valid when redirect=1.
REQ-006 halt_id  in  1  decoder halt for the instruction currently in IF/ID.
REQ-007 imem_rd  out  1  read request, asserted for one cycle per fetch.
REQ-008 imem_addr  out  16  fetch address (current PC), valid with imem_rd.
REQ-009 imem_ready  in  1  response strobe, at least 1 cycle after imem_rd.
REQ-010 imem_data  in  16  instruction word, valid with imem_ready.
REQ-011 ifid_instr  out  16  registered instruction to the decoder.
REQ-012 ifid_pc_inc  out  16  registered PC+2 of ifid_instr (JAL/JALR link, branch base).
REQ-013 ifid_valid  out  1  ifid_instr is a real fetched instruction.
REQ-014 halted  out  1  fetch stopped by HALT.
REQ-015 err  out  1  misaligned fetch detected (only when IFETCH_ALIGN_CHK_EN is defined).

Function
REQ-016 FSM states: FETCH (issue imem_rd), WAIT (request outstanding), HALTED.
REQ-017 In FETCH with stall=0 and skid buffer empty: imem_rd=1, imem_addr=PC, go to WAIT.
REQ-018 In FETCH with stall=1 or skid buffer full: imem_rd=0; remain in FETCH.
REQ-019 In WAIT on imem_ready with stall=0: IF/ID <= {imem_data, PC+2, valid=1}; PC <= PC+2; go to FETCH.
REQ-020 In WAIT on imem_ready with stall=1: capture imem_data and PC+2 in a one-entry skid buffer; PC <= PC+2; go to FETCH.
REQ-021 When stall falls with skid buffer full: load IF/ID from the buffer that edge and empty it, with no new fetch issued that cycle.
REQ-022 While stall=1: IF/ID outputs hold exactly; never lose or duplicate an instruction.
REQ-023 On redirect=1: PC <= redirect_pc; ifid_instr <= 16'h0800 (NOP); ifid_valid <= 0; skid buffer emptied; go to FETCH.
REQ-024 When redirect occurs in WAIT: the pending response is dropped, not written to IF/ID or the skid buffer, and the FSM stays in WAIT until that imem_ready arrives, then goes to FETCH.
REQ-025 redirect has priority over stall and over halt_id in the same cycle.
REQ-026 On halt_id=1 with ifid_valid=1 and redirect=0: go to HALTED; halted=1; outstanding response discarded; IF/ID holds the HALT word.
REQ-027 HALTED is left only by rst; imem_rd=0 throughout.
REQ-028 PC arithmetic: 16-bit unsigned, PC+2 wraps 16'hFFFE -> 16'h0000 silently.
REQ-029 Fetch throughput: at most one instruction per two cycles (request plus response).

Reset
REQ-030 On rst: PC=16'h0000, state FETCH, ifid_instr=16'h0800, ifid_pc_inc=16'h0000, ifid_valid=0, skid buffer empty, halted=0, err=0, imem_rd=0.
REQ-031 rst mid-request: the response to that request is ignored; first fetch after release is from 16'h0000.

Configuration
REQ-032 Macro IFETCH_ALIGN_CHK_EN defined: if a fetch would issue with PC[0]=1 (e.g. after redirect), imem_rd stays 0, err=1 sticky, go to HALTED with halted=1.
REQ-033 IFETCH_ALIGN_CHK_EN undefined: no alignment check; err is tied to 0; a misaligned PC is fetched as-is.

Verification
REQ-034 Reset release, memory ready 1 cycle after each request, words 16'h4020, 16'h0800 -> IF/ID shows 16'h4020/pc_inc 16'h0002, then 16'h0800/16'h0004, ifid_valid=1.
REQ-035 stall held 3 cycles while a response arrives -> IF/ID unchanged during stall; buffered word appears the edge stall falls; no fetch repeated or skipped.
REQ-036 redirect to 16'h0100 while request to 16'h0006 is outstanding -> stale response dropped, ifid_valid=0, next imem_addr=16'h0100.
REQ-037 halt_id=1 with ifid_valid=1 -> halted=1 next cycle, no further imem_rd until rst; redirect in the same cycle overrides halt.
REQ-038 PC=16'hFFFE fetch -> ifid_pc_inc=16'h0000, next imem_addr=16'h0000.
REQ-039 With IFETCH_ALIGN_CHK_EN: redirect to 16'h0013 -> no imem_rd, err=1, halted=1; without it: imem_addr=16'h0013 issued.
